// File: rtl/vchip8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vchip8_pkg
// Brief    : Shared keypad widths, key vector/code types and a priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
package vchip8_pkg;

    localparam int VCHIP8_NUM_KEYS = 16;
    localparam int VCHIP8_KEY_W    = 4;

    typedef logic [VCHIP8_NUM_KEYS-1:0] key_vec_t;
    typedef logic [VCHIP8_KEY_W-1:0]    key_code_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic key_code_t vchip8_lowest_set(input key_vec_t vec);
        key_code_t code;
        code = '0;
        for (int i = VCHIP8_NUM_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                code = key_code_t'(i);
            end
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vchip8_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : vchip8_debounce_bit
// Brief    : Two-flop synchroniser plus tick-driven integrator for one key.
// Revision : 1.0 - initial release
// ============================================================================
module vchip8_debounce_bit #(
    parameter int STABLE_SAMPLES = 4,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_key_state
);

    localparam int                 c_CNT_W    = $clog2(STABLE_SAMPLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_meta;
    logic               r_samp;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_state;

    // Polarity is folded in ahead of the first flop so a reset value of 0
    // already means "released" and no phantom press appears after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_samp <= 1'b0;
        end else begin
            r_meta <= i_raw ^ ACTIVE_LOW;
            r_samp <= r_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_state <= 1'b0;
        end else if (i_tick) begin
            if (r_samp == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_state <= ~r_state;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_key_state = r_state;

endmodule
`default_nettype wire

// File: rtl/vchip8_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : vchip8_key_debounce
// Brief    : Debounces the 16 CHIP-8 keys and captures one pending key press.
//            Event capture is built only when VCHIP8_KEY_EVENT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vchip8_key_debounce
    import vchip8_pkg::*;
#(
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [VCHIP8_NUM_KEYS-1:0] raw_in,
    output logic [VCHIP8_NUM_KEYS-1:0] key_state,
    output logic                       key_event_valid,
    output logic [VCHIP8_KEY_W-1:0]    key_event_code,
    input  logic                       key_event_ack
);

    localparam int                  c_TICK_W    = $clog2(SAMPLE_DIV);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLE_DIV - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    key_vec_t            w_key_state;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
        end
    end

    for (genvar gi = 0; gi < VCHIP8_NUM_KEYS; gi++) begin : g_key
        vchip8_debounce_bit #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_bit (
            .clk         (clk),
            .reset       (reset),
            .i_raw       (raw_in[gi]),
            .i_tick      (w_tick),
            .o_key_state (w_key_state[gi])
        );
    end

    assign key_state = w_key_state;

`ifdef VCHIP8_KEY_EVENT_EN
    key_vec_t  r_key_state_d;
    key_vec_t  w_press;
    logic      r_ev_valid;
    key_code_t r_ev_code;

    assign w_press = w_key_state & ~r_key_state_d;

    // A pending event blocks new ones unless it is being acknowledged in the
    // same cycle, in which case the fresh press replaces it without a gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_state_d <= '0;
            r_ev_valid    <= 1'b0;
            r_ev_code     <= '0;
        end else begin
            r_key_state_d <= w_key_state;
            if ((w_press != '0) && (!r_ev_valid || key_event_ack)) begin
                r_ev_valid <= 1'b1;
                r_ev_code  <= vchip8_lowest_set(w_press);
            end else if (r_ev_valid && key_event_ack) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign key_event_valid = r_ev_valid;
    assign key_event_code  = r_ev_code;
`else
    logic w_unused_ack;

    assign w_unused_ack    = key_event_ack;
    assign key_event_valid = 1'b0;
    assign key_event_code  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vchip8_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_vchip8_key_debounce
// Brief    : Directed self-checking bench for vchip8_key_debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vchip8_key_debounce;

`ifdef VCHIP8_KEY_EVENT_EN
    localparam bit c_EV = 1'b1;
`else
    localparam bit c_EV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] raw_in;
    logic [15:0] key_state;
    logic        key_event_valid;
    logic [3:0]  key_event_code;
    logic        key_event_ack;

    int n_checks = 0;
    int n_errors = 0;

    vchip8_key_debounce #(
        .SAMPLE_DIV     (4),
        .STABLE_SAMPLES (3),
        .ACTIVE_LOW     (1'b1)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .raw_in          (raw_in),
        .key_state       (key_state),
        .key_event_valid (key_event_valid),
        .key_event_code  (key_event_code),
        .key_event_ack   (key_event_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [15:0] exp, input int max_cyc,
                              output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (key_state !== exp && cyc < max_cyc);
        check_val(tag, 32'(key_state), 32'(exp));
    endtask

    function automatic logic [3:0] ev_code(input logic [3:0] code);
        return c_EV ? code : 4'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        bit  seen;
        logic [15:0] st_k11;

        // 1: reset with every key held down
        reset         = 1'b1;
        raw_in        = 16'h0000;
        key_event_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_val("rst_state", 32'(key_state), 32'h0);
            check_val("rst_valid", 32'(key_event_valid), 32'h0);
        end
        reset  = 1'b0;
        raw_in = 16'hFFFF;
        step(20);
        check_val("idle_state", 32'(key_state), 32'h0);

        // 2: clean press of key 5
        raw_in = 16'hFFDF;
        wait_state("press5_state", 16'h0020, 14, cyc);
        check_val("press5_min_lat", 32'(cyc >= 11), 32'h1);
        check_val("press5_valid_early", 32'(key_event_valid), 32'h0);
        step(1);
        check_val("press5_valid", 32'(key_event_valid), 32'(c_EV));
        check_val("press5_code", 32'(key_event_code), 32'(ev_code(4'h5)));
        key_event_ack = 1'b1;
        step(1);
        key_event_ack = 1'b0;
        check_val("ack5_valid", 32'(key_event_valid), 32'h0);
        raw_in = 16'hFFFF;
        wait_state("release5_state", 16'h0000, 14, cyc);
        step(2);
        check_val("release5_no_event", 32'(key_event_valid), 32'h0);

        // 3: bounce on key 5 never spans three ticks
        seen = 1'b0;
        for (int r = 0; r < 3; r++) begin
            raw_in = 16'hFFDF;
            for (int i = 0; i < 6; i++) begin
                step(1);
                if (key_state != 16'h0 || key_event_valid) seen = 1'b1;
            end
            raw_in = 16'hFFFF;
            for (int i = 0; i < 6; i++) begin
                step(1);
                if (key_state != 16'h0 || key_event_valid) seen = 1'b1;
            end
        end
        step(16);
        check_val("bounce_glitch", 32'(seen), 32'h0);
        check_val("bounce_state", 32'(key_state), 32'h0);
        check_val("bounce_valid", 32'(key_event_valid), 32'h0);

        // 4: keys 3 and 9 together, then key A while unacknowledged
        raw_in = 16'hFDF7;
        wait_state("dual_state", 16'h0208, 14, cyc);
        step(1);
        check_val("dual_valid", 32'(key_event_valid), 32'(c_EV));
        check_val("dual_code", 32'(key_event_code), 32'(ev_code(4'h3)));
        raw_in = 16'hF9F7;
        wait_state("keyA_state", 16'h0608, 14, cyc);
        step(2);
        check_val("keyA_valid", 32'(key_event_valid), 32'(c_EV));
        check_val("keyA_code_held", 32'(key_event_code), 32'(ev_code(4'h3)));

        // 5: ack in the rising cycle of key C, then a bare ack
        raw_in = 16'hFFFF;
        wait_state("release_all", 16'h0000, 14, cyc);
        raw_in = 16'hEFFF;
        wait_state("keyC_state", 16'h1000, 14, cyc);
        key_event_ack = 1'b1;
        step(1);
        key_event_ack = 1'b0;
        check_val("keyC_valid", 32'(key_event_valid), 32'(c_EV));
        check_val("keyC_code", 32'(key_event_code), 32'(ev_code(4'hC)));
        key_event_ack = 1'b1;
        step(1);
        key_event_ack = 1'b0;
        check_val("bare_ack_valid", 32'(key_event_valid), 32'h0);
        raw_in = 16'hFFFF;
        wait_state("releaseC_state", 16'h0000, 14, cyc);

        // 6: reset part-way through key 7's debounce
        raw_in = 16'hFF7F;
        step(10);
        check_val("k7_partial", 32'(key_state), 32'h0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_val("midrst_state", 32'(key_state), 32'h0);
        check_val("midrst_valid", 32'(key_event_valid), 32'h0);
        check_val("midrst_code", 32'(key_event_code), 32'h0);
        step(11);
        st_k11 = key_state;
        check_val("k7_fresh_k11", 32'(st_k11), 32'h0);
        step(1);
        check_val("k7_fresh_k12", 32'(key_state), 32'h0080);
        step(1);
        check_val("k7_valid", 32'(key_event_valid), 32'(c_EV));
        check_val("k7_code", 32'(key_event_code), 32'(ev_code(4'h7)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vchip8_key_debounce.md
# vchip8_key_debounce

Conditions the 16 raw CHIP-8 keypad/switch inputs before they reach the switch-control PIO's `in_port`. It synchronises each input, debounces it with a shared sample tick and per-key integrators, and presents a stable 16-bit key vector. It also captures a single key-press event (code plus valid flag, cleared by acknowledge) so the CPU can service `Fx0A` (wait for key) without polling for edges.

## Interface
- `SAMPLE_DIV`, 50000: clock cycles per debounce sample tick (1 ms at 50 MHz); legal range ≥ 2.
- `STABLE_SAMPLES`, 4: consecutive differing samples required to flip a key's stable state; legal range ≥ 1.
- `ACTIVE_LOW`, 1: 1 means a raw level of 0 is "pressed"; 0 means a raw level of 1 is "pressed".

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `raw_in`  in  16: asynchronous key/switch levels; bit n is key n (0x0–0xF).
- `key_state`  out  16: debounced state, 1 = pressed; drives the switch-control `in_port`.
- `key_event_valid`  out  1: a captured press is pending.
- `key_event_code`  out  4: index of the captured key.
- `key_event_ack`  in  1: consumer acknowledge for the pending event.

## Operation
- **Synchroniser:** two-flop synchroniser per bit. When `ACTIVE_LOW`=1 the synchronised value is inverted to give `samp[15:0]`, where 1 = pressed.
- **Tick counter:** `tick_cnt` counts 0..SAMPLE_DIV-1 and wraps to 0. `tick` is high for the one cycle in which `tick_cnt`==SAMPLE_DIV-1.
- **Per-key integrator:** width clog2(STABLE_SAMPLES+1). On `tick`:
  - if `samp[n]`==`key_state[n]`, the counter clears to 0;
  - otherwise, if counter==STABLE_SAMPLES-1, `key_state[n]` toggles and the counter clears;
  - otherwise the counter increments.
  - Counters hold between ticks.
  - A glitch shorter than STABLE_SAMPLES consecutive ticks never reaches `key_state`.
- **Press detection:** `press[n]` = `key_state[n]` & ~`key_state_d[n]`, where `key_state_d` is `key_state` delayed one cycle. Several bits may rise on the same tick.
- **Event capture rules:**
  - The lowest set index of `press` is encoded into `key_event_code`.
  - If `key_event_valid`=0 and `press`≠0, the event is captured and `key_event_valid` goes to 1.
  - If `key_event_valid`=1 and `key_event_ack`=0, new presses are dropped; the first press wins and the pending event holds.
  - If `key_event_ack`=1 while valid and `press`=0, `key_event_valid` clears next cycle.
  - If `key_event_ack`=1 while valid and `press`≠0 in the same cycle, the new press is captured: valid stays 1 and the code updates.
  - `key_event_ack` while not valid is ignored.
- Releases never generate events.
- **Reset:** while `reset`=1 at a clock edge, the synchroniser flops, `tick_cnt`, all integrators, `key_state`, `key_state_d`, `key_event_valid` and `key_event_code` all go to 0.
  - The synchroniser reset value is the "released" raw level, so no spurious press is seen after reset.
  - Reset mid-debounce discards all partial counts.

## Timing
- Outputs are registered; there is no combinational path from input to output.
- A raw edge reaches `samp` after 2 cycles.
- `key_state` flips on the edge following the STABLE_SAMPLES-th consecutive differing tick.
  - Worst case from raw edge: 2 + STABLE_SAMPLES·SAMPLE_DIV cycles.
  - Best case: 2 + (STABLE_SAMPLES-1)·SAMPLE_DIV + 1 cycles.
- `key_event_valid` rises 1 cycle after the corresponding `key_state` rise.
- The ack takes effect at the next edge; the valid/ack handshake completes in a single cycle.
- The first `tick` after reset deasserts occurs SAMPLE_DIV cycles later.

## Configuration
- `VCHIP8_KEY_EVENT_EN` defined: press detection, `key_state_d` and the event registers are built as described above.
- `VCHIP8_KEY_EVENT_EN` undefined:
  - the event logic is omitted;
  - `key_event_valid` and `key_event_code` are tied to 0;
  - `key_event_ack` is ignored;
  - the `key_state` path is unchanged.

## Structure
- Shared package `vchip8_pkg` holds:
  - `VCHIP8_NUM_KEYS` = 16;
  - `VCHIP8_KEY_W` = 4;
  - the `key_vec_t` (16-bit) and `key_code_t` (4-bit) typedefs;
  - a lowest-set-bit priority-encode function.
- One sub-module, `vchip8_debounce_bit`: the synchroniser plus integrator for a single key. It takes `tick` and `ACTIVE_LOW`/`STABLE_SAMPLES` as inputs/parameters and is instantiated 16 times via generate.
- The tick counter, press detection and event capture stay in the top module.

## Test plan
Bench parameters: SAMPLE_DIV=4, STABLE_SAMPLES=3, ACTIVE_LOW=1, `raw_in` idle at 0xFFFF.
1. **Reset state:** assert `reset` for 3 cycles with `raw_in`=0x0000 → `key_state`=0x0000 and `key_event_valid`=0 throughout reset.
2. **Clean press:** drive `raw_in`=0xFFDF (key 5 pressed) and hold → `key_state`=0x0020 within 2+12 cycles; 1 cycle later `key_event_valid`=1 and `key_event_code`=5.
3. **Bounce rejection:** toggle bit 5 low for 6 cycles (fewer than 3 consecutive ticks), then high → `key_state` stays 0x0000 and no event is raised.
4. **Simultaneous press:** keys 3 and 9 pressed on the same cycle → `key_state`=0x0208 and `key_event_code`=3. With no ack, a later press of key 0xA keeps code 3.
5. **Ack plus new press:** pulse `key_event_ack` in the exact cycle key 0xC's `key_state` bit rises → `key_event_valid` stays 1 and `key_event_code`=0xC. An ack with no press → valid=0 next cycle.
6. **Reset mid-debounce:** key 7 held low for 2 ticks, then `reset` for 1 cycle → all outputs are 0. After release of reset, key 7 still needs 3 fresh ticks before `key_state[7]`=1.
